// File: rtl/taxi_gt_qpll_reset_if.sv
`default_nettype none
// ============================================================================
// Module      : taxi_gt_qpll_reset_if
// Description : Request/status bundle between the channel-side logic, the
//               QPLL ports and the shared QPLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface taxi_gt_qpll_reset_if #(
  parameter int CH_CNT = 4
);
  logic              qpll_pd_out;
  logic              qpll_reset_out;
  logic              qpll_lock_in;
  logic [CH_CNT-1:0] ch_req_in;
  logic [CH_CNT-1:0] ch_reset_req_in;
  logic              qpll_lock_out;
  logic              qpll_active_out;
  logic [7:0]        retry_cnt_out;

  // Requesting side: channels raise demand/reset levels, the QPLL reports raw lock
  modport master (
    output qpll_lock_in,
    output ch_req_in,
    output ch_reset_req_in,
    input  qpll_pd_out,
    input  qpll_reset_out,
    input  qpll_lock_out,
    input  qpll_active_out,
    input  retry_cnt_out
  );

  // Sequencer side
  modport slave (
    input  qpll_lock_in,
    input  ch_req_in,
    input  ch_reset_req_in,
    output qpll_pd_out,
    output qpll_reset_out,
    output qpll_lock_out,
    output qpll_active_out,
    output retry_cnt_out
  );
endinterface
`default_nettype wire

// File: rtl/taxi_gt_qpll_reset.sv
`default_nettype none
// ============================================================================
// Module      : taxi_gt_qpll_reset
// Description : Shared QPLL power/reset sequencer. Powers the QPLL on demand,
//               merges channel reset requests into one reset sequence,
//               qualifies lock and retries on lock timeout or lock loss.
// Revision    : 1.0 - initial release
// ============================================================================
module taxi_gt_qpll_reset #(
  parameter int CH_CNT    = 4,
  parameter bit ALWAYS_ON = 1'b0,
  parameter int CNT_W     = 8,
  parameter int TO_W      = 16
) (
  input wire                   clk,
  input wire                   rst,
  taxi_gt_qpll_reset_if.slave  bus
);

  localparam int W = (CNT_W > TO_W) ? CNT_W : TO_W;

  // Last count value of the power-up / reset-hold interval and of the lock timeout
  localparam logic [W-1:0]     IVL_LAST  = W'((64'd1 << CNT_W) - 64'd1);
  localparam logic [W-1:0]     TO_LAST   = W'((64'd1 << TO_W) - 64'd1);
  // Qualify count that must be reached with lock still high before declaring lock
  localparam logic [CNT_W:0]   QUAL_DONE = (CNT_W + 1)'(64'd1 << CNT_W);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PWRUP     = 3'd1;
  localparam logic [2:0] ST_RESET     = 3'd2;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd3;
  localparam logic [2:0] ST_LOCKED    = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [W-1:0]      cnt;
  logic [CNT_W:0]    qual;
  logic [7:0]        retry_cnt;
  logic              retry_inc;
  logic              lock_meta;
  logic              lock_sync;
  logic              pd;
  logic              reset;
  logic              lock_out;
  logic              active;
  logic              pd_nxt;
  logic              reset_nxt;
  logic              lock_out_nxt;
  logic              active_nxt;
  logic [CH_CNT-1:0] ch_req;
  logic [CH_CNT-1:0] ch_reset_req;
  logic              req;
  logic              rreq;

  assign ch_req       = bus.ch_req_in;
  assign ch_reset_req = bus.ch_reset_req_in;
  // A reset request only counts from a channel that is actually using the QPLL
  assign req          = ALWAYS_ON | (|ch_req);
  assign rreq         = |(ch_reset_req & ch_req);

  // Two-flop synchronizer bringing the raw QPLL lock into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= bus.qpll_lock_in;
      lock_sync <= lock_meta;
    end
  end

  // State register with interval/qualify counters, retry counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      qual      <= '0;
      retry_cnt <= 8'd0;
      pd        <= 1'b1;
      reset     <= 1'b1;
      lock_out  <= 1'b0;
      active    <= 1'b0;
    end else begin
      state <= state_nxt;
      // Interval counter restarts on every state change; a held reset request pins it at 0
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == ST_RESET && rreq) begin
        cnt <= '0;
      end else if (state == ST_PWRUP || state == ST_RESET || state == ST_WAIT_LOCK) begin
        cnt <= cnt + W'(1);
      end
      // Qualify count measures consecutive synced-lock cycles inside WAIT_LOCK
      if (state_nxt != state || state != ST_WAIT_LOCK || !lock_sync) begin
        qual <= '0;
      end else begin
        qual <= qual + (CNT_W + 1)'(1);
      end
      if (retry_inc && retry_cnt != 8'hFF) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
      pd       <= pd_nxt;
      reset    <= reset_nxt;
      lock_out <= lock_out_nxt;
      active   <= active_nxt;
    end
  end

  // Next-state selection; demand loss outranks lock loss/timeout, which outrank reset requests
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    if (!req) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_PWRUP;
        end
        ST_PWRUP: begin
          if (cnt == IVL_LAST) state_nxt = ST_RESET;
        end
        ST_RESET: begin
          if (!rreq && cnt == IVL_LAST) state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (cnt == TO_LAST) begin
            state_nxt = ST_RESET;
            retry_inc = 1'b1;
          end else if (lock_sync && qual == QUAL_DONE) begin
            state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (!lock_sync) begin
            state_nxt = ST_RESET;
            retry_inc = 1'b1;
          end else if (rreq) begin
            state_nxt = ST_RESET;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they change on the same edge as the state
  always_comb begin
    pd_nxt       = (state_nxt == ST_IDLE);
    reset_nxt    = (state_nxt == ST_IDLE) || (state_nxt == ST_PWRUP) || (state_nxt == ST_RESET);
    lock_out_nxt = (state_nxt == ST_LOCKED);
    active_nxt   = (state_nxt != ST_IDLE);
  end

  assign bus.qpll_pd_out     = pd;
  assign bus.qpll_reset_out  = reset;
  assign bus.qpll_lock_out   = lock_out;
  assign bus.qpll_active_out = active;
  assign bus.retry_cnt_out   = retry_cnt;

endmodule
`default_nettype wire
